// File: rtl/mul_div_seq_ctrl.sv
// mul_div_seq_ctrl: operand launch / result capture stage around the
// combinational mul_div array. Operands are registered onto the array on
// input handshake, the array settles for SETTLE_CYCLES edges, then the
// product is captured and presented on the output handshake.
// Optional build macro: ZERO_BYPASS_EN (zero operand skips the settle wait).
module mul_div_seq_ctrl #(
  parameter int DIVISOR_LENGTH  = 3,
  parameter int DEVIDENT_LENGTH = 3,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          In_Valid,
  output logic                          In_Ready,
  input  logic [DIVISOR_LENGTH-1:0]     In_OperX,
  input  logic [DEVIDENT_LENGTH-1:0]    In_OperY,
  output logic [DIVISOR_LENGTH-1:0]     Array_OperX,
  output logic [DEVIDENT_LENGTH-1:0]    Array_OperY,
  input  logic [2*DIVISOR_LENGTH-1:0]   Array_Result,
  output logic                          Out_Valid,
  input  logic                          Out_Ready,
  output logic [2*DIVISOR_LENGTH-1:0]   Out_Result,
  output logic                          Busy
);

  if (DEVIDENT_LENGTH != DIVISOR_LENGTH) begin : g_len_chk
    $fatal(1, "DEVIDENT_LENGTH must equal DIVISOR_LENGTH");
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_settle_chk
    $fatal(1, "SETTLE_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       accept;
  logic       capture;
  logic       bypass;

  assign In_Ready  = !RST && (state == IDLE || (state == HOLD && Out_Ready));
  assign accept    = In_Valid && In_Ready;
  assign Out_Valid = (state == HOLD);
  assign Busy      = (state != IDLE);

  // Next-state and settle counter; an accept overrides the HOLD->IDLE exit
  // so the output handshake and the next launch share one edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    bypass    = 1'b0;
    case (state)
      SETTLE: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (Out_Ready) state_nxt = IDLE;
      end
      default: ;
    endcase
    if (accept) begin
      cnt_nxt   = 4'(SETTLE_CYCLES - 1);
      state_nxt = SETTLE;
`ifdef ZERO_BYPASS_EN
      if (In_OperX == '0 || In_OperY == '0) begin
        bypass    = 1'b1;
        state_nxt = HOLD;
      end
`else
      bypass = 1'b0;
`endif
    end
  end

  // State, counter, operand launch and result capture registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      Array_OperX <= '0;
      Array_OperY <= '0;
      Out_Result  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        Array_OperX <= In_OperX;
        Array_OperY <= In_OperY;
      end
      if (capture)     Out_Result <= Array_Result;
      else if (bypass) Out_Result <= '0;
    end
  end

endmodule

// File: tb/tb_mul_div_seq_ctrl.sv
// Randomized bench for mul_div_seq_ctrl against a transaction-level model:
// each accepted operand pair becomes a pending product due a fixed number of
// edges later, then is presented until the consumer takes it.
module tb_mul_div_seq_ctrl;
  localparam int W      = 3;
  localparam int SETTLE = 2;

  logic           clk = 1'b0;
  logic           rst, in_valid, out_ready;
  logic           in_ready, out_valid, busy;
  logic [W-1:0]   in_x, in_y, arr_x, arr_y;
  logic [2*W-1:0] arr_res, out_result;

  int n_cmp = 0;
  int n_bad = 0;

  // Stand-in for the combinational array.
  assign arr_res = {{W{1'b0}}, arr_x} * {{W{1'b0}}, arr_y};

  always #5 clk = ~clk;

  mul_div_seq_ctrl #(
    .DIVISOR_LENGTH (W),
    .DEVIDENT_LENGTH(W),
    .SETTLE_CYCLES  (SETTLE)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .In_Valid    (in_valid),
    .In_Ready    (in_ready),
    .In_OperX    (in_x),
    .In_OperY    (in_y),
    .Array_OperX (arr_x),
    .Array_OperY (arr_y),
    .Array_Result(arr_res),
    .Out_Valid   (out_valid),
    .Out_Ready   (out_ready),
    .Out_Result  (out_result),
    .Busy        (busy)
  );

  // Reference model: one in-flight product with edges remaining, one
  // presented product, the last launched operands.
  bit m_pending = 0;
  int m_left    = 0;
  int m_prod    = 0;
  bit m_valid   = 0;
  int m_result  = 0;
  int m_x = 0, m_y = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    return !rst && !m_pending && (!m_valid || out_ready);
  endfunction

  task automatic cycle(input logic r, input logic v, input int x, input int y,
                       input logic ordy);
    bit acc;
    rst = r; in_valid = v; in_x = W'(x); in_y = W'(y); out_ready = ordy;
    @(negedge clk);
    check("in_ready",   int'(in_ready),   int'(exp_ready()));
    check("out_valid",  int'(out_valid),  int'(m_valid));
    check("busy",       int'(busy),       int'(m_pending || m_valid));
    check("out_result", int'(out_result), m_result);
    check("array_x",    int'(arr_x),      m_x);
    check("array_y",    int'(arr_y),      m_y);
    acc = v && exp_ready();
    @(posedge clk);
    if (r) begin
      m_pending = 0; m_valid = 0; m_result = 0; m_x = 0; m_y = 0;
    end else begin
      if (m_valid && ordy) m_valid = 0;
      if (m_pending) begin
        m_left--;
        if (m_left == 0) begin
          m_pending = 0; m_valid = 1; m_result = m_prod;
        end
      end
      if (acc) begin
        m_x = x; m_y = y;
`ifdef ZERO_BYPASS_EN
        if (x == 0 || y == 0) begin
          m_valid = 1; m_result = 0;
        end else begin
          m_pending = 1; m_left = SETTLE; m_prod = x * y;
        end
`else
        m_pending = 1; m_left = SETTLE; m_prod = x * y;
`endif
      end
    end
    #1;
  endtask

  initial begin
    rst = 1; in_valid = 0; in_x = '0; in_y = '0; out_ready = 0;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 5, 3, 1);
    // 5*3 with consumer ready
    cycle(0, 1, 5, 3, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
    // back-to-back 7*7 then 6*2
    for (int i = 0; i < 4; i++) cycle(0, 1, 7, 7, 1);
    for (int i = 0; i < 5; i++) cycle(0, 1, 6, 2, 1);
    // backpressure on 4*6 with a competing request
    cycle(0, 1, 4, 6, 0);
    for (int i = 0; i < 7; i++) cycle(0, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
    // reset mid-operation
    cycle(0, 1, 3, 3, 1);
    cycle(1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
    // zero operand
    cycle(0, 1, 0, 5, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      int x, y;
      x = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 7));
      y = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 7));
      cycle(logic'($urandom_range(0, 40) == 0), logic'($urandom_range(0, 2) != 0),
            x, y, logic'($urandom_range(0, 2) != 0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
